// File: rtl/regfile_pkg.sv
// Shared constants and types for the writeback-terminating register file.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd2;
    localparam reg_addr_t REG_A0   = 5'd10;

endpackage

// File: rtl/regfile_read_port.sv
// One decode read port: write-first bypass from W, hard-wired zero for x0, else storage.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  reg_addr_t          addr_i,
    input  logic [WIDTH-1:0]   word_i,
    input  logic               wr_en_i,
    input  reg_addr_t          wr_addr_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    output logic [WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        // wr_en_i is already qualified with a non-zero destination by the top.
        if (wr_en_i && (wr_addr_i == addr_i)) begin
            data_o = wr_data_i;
        end else if (addr_i != REG_ZERO) begin
            data_o = word_i;
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Register file fed by the writeback stage, two bypassed decode read ports, commit counter.
// Optional REGFILE_A0_DEBUG_EN adds A0Dbg, the raw stored value of x10.
module regfile_wb_sink
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] SP_INIT   = WIDTH'(32'h0001_FFFC),
    parameter int               CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RegWriteW,
    input  logic [4:0]           RdW,
    input  logic [WIDTH-1:0]     ResultW,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    output logic [WIDTH-1:0]     RD1D,
    output logic [WIDTH-1:0]     RD2D,
`ifdef REGFILE_A0_DEBUG_EN
    output logic [WIDTH-1:0]     A0Dbg,
`endif
    output logic [CNT_WIDTH-1:0] WbCountW
);

    logic [WIDTH-1:0]     regs_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] wb_count_q;
    logic [CNT_WIDTH-1:0] wb_count_d;
    logic                 wr_en;

    // RegWriteW gates first so an unknown RdW during idle cycles cannot decode a write.
    assign wr_en      = RegWriteW && (RdW != REG_ZERO);
    assign wb_count_d = wb_count_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[REG_SP] <= SP_INIT;
        end else if (wr_en) begin
            regs_q[RdW] <= ResultW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_q <= '0;
        end else if (wr_en) begin
            wb_count_q <= wb_count_d;
        end
    end

    assign WbCountW = wb_count_q;

    regfile_read_port #(.WIDTH(WIDTH)) u_rd1 (
        .addr_i    (Rs1D),
        .word_i    (regs_q[Rs1D]),
        .wr_en_i   (wr_en),
        .wr_addr_i (RdW),
        .wr_data_i (ResultW),
        .data_o    (RD1D)
    );

    regfile_read_port #(.WIDTH(WIDTH)) u_rd2 (
        .addr_i    (Rs2D),
        .word_i    (regs_q[Rs2D]),
        .wr_en_i   (wr_en),
        .wr_addr_i (RdW),
        .wr_data_i (ResultW),
        .data_o    (RD2D)
    );

`ifdef REGFILE_A0_DEBUG_EN
    assign A0Dbg = regs_q[REG_A0];
`endif

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed bench for regfile_wb_sink; a second instance with a 4-bit counter covers wrap.
module tb_regfile_wb_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D, RD2D, WbCountW;
    logic [31:0] RD1D_4, RD2D_4;
    logic [3:0]  WbCountW_4;
`ifdef REGFILE_A0_DEBUG_EN
    logic [31:0] A0Dbg, A0Dbg_4;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    regfile_wb_sink u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RD1D      (RD1D),
        .RD2D      (RD2D),
`ifdef REGFILE_A0_DEBUG_EN
        .A0Dbg     (A0Dbg),
`endif
        .WbCountW  (WbCountW)
    );

    regfile_wb_sink #(.CNT_WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RD1D      (RD1D_4),
        .RD2D      (RD2D_4),
`ifdef REGFILE_A0_DEBUG_EN
        .A0Dbg     (A0Dbg_4),
`endif
        .WbCountW  (WbCountW_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
        Rs1D = 5'd2; Rs2D = 5'd5;
        step(); step();
        #1;
        chk("reset_sp", RD1D, 32'h0001_FFFC);
        chk("reset_x5", RD2D, 32'h0);
        chk("reset_cnt", WbCountW, 32'h0);
        chk("reset_cnt4", {28'h0, WbCountW_4}, 32'h0);
        $display("txn reset rd1=%h rd2=%h cnt=%0d", RD1D, RD2D, WbCountW);

        @(negedge clk);
        rst_n = 1'b1;
        step();

        // x5 <= DEADBEEF, read through port 1 a cycle later
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEAD_BEEF; Rs1D = 5'd1;
        #1;
        chk("pre_write_x1", RD1D, 32'h0);
        step();
        RegWriteW = 1'b0; Rs1D = 5'd5;
        #1;
        chk("write_read_x5", RD1D, 32'hDEAD_BEEF);
        chk("write_cnt", WbCountW, 32'd1);
        $display("txn write x5 rd1=%h cnt=%0d", RD1D, WbCountW);

        // x7 <= 0x11, then same-cycle bypass of 0x22 on both ports
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h11;
        step();
        RegWriteW = 1'b0; Rs1D = 5'd7; Rs2D = 5'd7;
        #1;
        chk("x7_stored", RD1D, 32'h11);
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h22;
        #1;
        chk("bypass_rd1", RD1D, 32'h22);
        chk("bypass_rd2", RD2D, 32'h22);
        $display("txn bypass x7 rd1=%h rd2=%h", RD1D, RD2D);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("x7_after", RD1D, 32'h22);
        chk("cnt_after_bypass", WbCountW, 32'd3);

        // write to x0 must be invisible and uncounted
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFF_FFFF; Rs1D = 5'd0; Rs2D = 5'd5;
        #1;
        chk("x0_same_cycle", RD1D, 32'h0);
        chk("x5_held", RD2D, 32'hDEAD_BEEF);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("x0_after", RD1D, 32'h0);
        chk("x0_cnt", WbCountW, 32'd3);
        $display("txn x0 write rd1=%h cnt=%0d", RD1D, WbCountW);

        // unknown RdW/ResultW while RegWriteW=0
        RdW = 5'bxxxxx; ResultW = 32'hxxxx_xxxx;
        step();
        #1;
        chk("idle_x_x5", RD2D, 32'hDEAD_BEEF);
        chk("idle_x_cnt", WbCountW, 32'd3);

        // 16 writes to x1; the 4-bit counter passes 14, 15, 0
        exp_cnt = 32'd3;
        Rs1D = 5'd1;
        for (int k = 0; k < 16; k++) begin
            RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'(k);
            step();
            exp_cnt = exp_cnt + 32'd1;
            chk("wrap_cnt32", WbCountW, exp_cnt);
            chk("wrap_cnt4", {28'h0, WbCountW_4}, exp_cnt & 32'hF);
            $display("txn wr x1=%0d cnt=%0d cnt4=%0d", k, WbCountW, WbCountW_4);
        end
        RegWriteW = 1'b0;
        #1;
        chk("x1_last", RD1D, 32'd15);

`ifdef REGFILE_A0_DEBUG_EN
        RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'hA0A0;
        #1;
        chk("a0dbg_lag", A0Dbg, 32'h0);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("a0dbg_after", A0Dbg, 32'hA0A0);
        $display("txn a0 write a0dbg=%h", A0Dbg);
`endif

        // reset asserted mid-cycle with a pending write to x9
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'd5; Rs1D = 5'd5; Rs2D = 5'd2;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_x5", RD1D, 32'h0);
        chk("async_rst_cnt", WbCountW, 32'h0);
        chk("async_rst_sp", RD2D, 32'h0001_FFFC);
        step();
        RegWriteW = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        Rs1D = 5'd9;
        #1;
        chk("rst_override_x9", RD1D, 32'h0);
        chk("rst_override_cnt", WbCountW, 32'h0);
        $display("txn reset override x9=%h cnt=%0d", RD1D, WbCountW);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
